// File: rtl/plic_gateway_array.sv
// Bank of PLIC interrupt gateways: optional irq synchroniser, then one independent
// IDLE/PEND/ACTIVE gateway per source with a saturating edge-request counter.

module plic_gw_src #(
    parameter int MAX_PEND = 7,
    parameter int CNT_W    = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_s,
    input  logic tm,
    input  logic claim_hit,
    input  logic comp_hit,
    output logic ip,
    output logic active
);
    typedef enum logic [1:0] {IDLE, PEND, ACTIVE} state_t;

    state_t             state_q;
    logic               irq_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rise, go_pend, consume;

    assign rise    = irq_s & ~irq_q;
    assign go_pend = (state_q == IDLE) && (tm ? (cnt_q != '0) : irq_s);
    assign consume = go_pend & tm;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            cnt_q   <= '0;
            ip      <= 1'b0;
            active  <= 1'b0;
        end else begin
            irq_q <= irq_s;
            // A rise and a consume in the same cycle cancel out.
            if (!tm)
                cnt_q <= '0;
            else if (rise && !consume) begin
                if (cnt_q != CNT_W'(MAX_PEND))
                    cnt_q <= cnt_q + CNT_W'(1);
            end else if (!rise && consume)
                cnt_q <= cnt_q - CNT_W'(1);

            case (state_q)
                IDLE: if (go_pend) begin
                    state_q <= PEND;
                    ip      <= 1'b1;
                end
                PEND: if (claim_hit) begin
                    state_q <= ACTIVE;
                    ip      <= 1'b0;
                    active  <= 1'b1;
                end
                ACTIVE: if (comp_hit) begin
                    state_q <= IDLE;
                    active  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ip      <= 1'b0;
                    active  <= 1'b0;
                end
            endcase
        end
    end
endmodule

module plic_gateway_array #(
    parameter  int SOURCES     = 32,
    parameter  int SYNC_STAGES = 2,
    parameter  int MAX_PEND    = 7,
    localparam int CNT_W       = $clog2(MAX_PEND + 1),
    localparam int ID_W        = $clog2(SOURCES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SOURCES-1:0] irq_i,
    input  logic [SOURCES-1:0] tm_i,
    input  logic               claim_i,
    input  logic [ID_W-1:0]    claim_id_i,
    input  logic               comp_i,
    input  logic [ID_W-1:0]    comp_id_i,
    output logic [SOURCES-1:0] ip_o,
    output logic [SOURCES-1:0] active_o
);
    logic [SOURCES-1:0] irq_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign irq_s = irq_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][SOURCES-1:0] sync_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)
                    sync_q <= '0;
                else begin
                    sync_q[0] <= irq_i;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        sync_q[i] <= sync_q[i-1];
                end
            end
            assign irq_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ID 0 and IDs above SOURCES never match a lane, so they fall through silently.
    for (genvar g = 0; g < SOURCES; g++) begin : g_src
        localparam logic [ID_W-1:0] SRC_ID = ID_W'(g + 1);
        plic_gw_src #(.MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) u_src (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .irq_s     (irq_s[g]),
            .tm        (tm_i[g]),
            .claim_hit (claim_i && (claim_id_i == SRC_ID)),
            .comp_hit  (comp_i && (comp_id_i == SRC_ID)),
            .ip        (ip_o[g]),
            .active    (active_o[g])
        );
    end
endmodule

// File: tb/tb_plic_gateway_array.sv
// Directed bench for plic_gateway_array (32 sources, 2 sync stages, MAX_PEND 7).
module tb_plic_gateway_array;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] irq_i, tm_i;
    logic        claim_i, comp_i;
    logic [5:0]  claim_id_i, comp_id_i;
    logic [31:0] ip_o, active_o;
    int          n_cmp = 0, n_bad = 0;
    int          rounds;

    plic_gateway_array #(.SOURCES(32), .SYNC_STAGES(2), .MAX_PEND(7)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .irq_i      (irq_i),
        .tm_i       (tm_i),
        .claim_i    (claim_i),
        .claim_id_i (claim_id_i),
        .comp_i     (comp_i),
        .comp_id_i  (comp_id_i),
        .ip_o       (ip_o),
        .active_o   (active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input int b);
        irq_i[b] = 1'b1;
        step();
        irq_i[b] = 1'b0;
        step();
    endtask

    task automatic claim(input logic [5:0] id);
        claim_i = 1'b1; claim_id_i = id;
        step();
        claim_i = 1'b0; claim_id_i = '0;
    endtask

    task automatic comp(input logic [5:0] id);
        comp_i = 1'b1; comp_id_i = id;
        step();
        comp_i = 1'b0; comp_id_i = '0;
    endtask

    // Serve the source until it stops re-pending; returns number of rounds served.
    task automatic run_rounds(input int b, output int n);
        bit seen;
        n = 0;
        for (int r = 0; r < 12; r++) begin
            seen = 1'b0;
            for (int w = 0; w < 6 && !seen; w++) begin
                if (ip_o[b]) seen = 1'b1;
                else step();
            end
            if (!seen) break;
            claim(6'(b + 1));
            comp(6'(b + 1));
            n++;
        end
    endtask

    initial begin
        rst_i = 1'b1; irq_i = '0; tm_i = '0;
        claim_i = 1'b0; comp_i = 1'b0; claim_id_i = '0; comp_id_i = '0;
        step(); step();
        chk("rst_ip", ip_o, 32'h0);
        chk("rst_active", active_o, 32'h0);
        rst_i = 1'b0;
        step();

        // Level source 5 (bit 4)
        irq_i[4] = 1'b1;
        step();                                  // E0
        step(); chk("lvl_e1", 32'(ip_o[4]), 32'h0);
        step(); chk("lvl_e2", 32'(ip_o[4]), 32'h1);
        claim(6'd5);
        chk("lvl_claim_act", 32'(active_o[4]), 32'h1);
        chk("lvl_claim_ip", 32'(ip_o[4]), 32'h0);
        comp(6'd5);
        chk("lvl_comp_idle", {30'h0, active_o[4], ip_o[4]}, 32'h0);
        step(); chk("lvl_repend", 32'(ip_o[4]), 32'h1);
        irq_i[4] = 1'b0;
        step(); step(); step();
        chk("lvl_latched", 32'(ip_o[4]), 32'h1);
        claim(6'd5); comp(6'd5);
        step(); step();
        chk("lvl_done", {30'h0, active_o[4], ip_o[4]}, 32'h0);

        // Edge source 1 (bit 0): three queued pulses -> three rounds
        tm_i[0] = 1'b1;
        step();
        pulse(0); pulse(0); pulse(0);
        step(); step();
        chk("edge_ip", 32'(ip_o[0]), 32'h1);
        run_rounds(0, rounds);
        chk("edge_rounds", 32'(rounds), 32'd3);
        chk("edge_quiet", 32'(ip_o[0]), 32'h0);

        // Edge saturation on source 2 (bit 1): 10 pulses while ACTIVE -> 7 rounds
        tm_i[1] = 1'b1;
        step();
        pulse(1); step(); step();
        chk("sat_pend", 32'(ip_o[1]), 32'h1);
        claim(6'd2);
        chk("sat_active", 32'(active_o[1]), 32'h1);
        for (int i = 0; i < 10; i++) pulse(1);
        step(); step();
        comp(6'd2);
        run_rounds(1, rounds);
        chk("sat_rounds", 32'(rounds), 32'd7);

        // Ignored requests against source 3 (bit 2) in PEND
        irq_i[2] = 1'b1;
        step(); step(); step();
        chk("ign_setup", ip_o, 32'h0000_0004);
        claim(6'd0);
        chk("ign_id0_ip", ip_o, 32'h0000_0004);
        chk("ign_id0_act", active_o, 32'h0);
        claim(6'd33);
        chk("ign_id33_ip", ip_o, 32'h0000_0004);
        chk("ign_id33_act", active_o, 32'h0);
        comp(6'd3);
        chk("ign_comp_ip", ip_o, 32'h0000_0004);
        chk("ign_comp_act", active_o, 32'h0);
        irq_i[2] = 1'b0;
        step(); step(); step();
        claim(6'd3); comp(6'd3);
        step(); step();

        // Same-cycle claim 2 / complete 7
        tm_i[1] = 1'b0;
        irq_i[6] = 1'b1;
        step(); step(); step();
        claim(6'd7);
        irq_i[6] = 1'b0;
        irq_i[1] = 1'b1;
        step(); step(); step();
        chk("sc_setup_ip", ip_o, 32'h0000_0002);
        chk("sc_setup_act", active_o, 32'h0000_0040);
        claim_i = 1'b1; claim_id_i = 6'd2; comp_i = 1'b1; comp_id_i = 6'd7;
        step();
        claim_i = 1'b0; comp_i = 1'b0;
        chk("sc_both_ip", ip_o, 32'h0);
        chk("sc_both_act", active_o, 32'h0000_0002);
        comp(6'd2);
        step();
        chk("sc_repend", ip_o, 32'h0000_0002);
        claim_i = 1'b1; claim_id_i = 6'd2; comp_i = 1'b1; comp_id_i = 6'd2;
        step();
        claim_i = 1'b0; comp_i = 1'b0;
        chk("sc_claim_wins_act", active_o, 32'h0000_0002);
        chk("sc_claim_wins_ip", ip_o, 32'h0);
        irq_i[1] = 1'b0;
        step(); step(); step();
        comp(6'd2);
        step();

        // Rise coinciding with consume on source 4 (bit 3)
        tm_i[3] = 1'b1;
        step();
        pulse(3); step(); step();
        claim(6'd4);
        pulse(3); step(); step();
        irq_i[3] = 1'b1;
        step();
        irq_i[3] = 1'b0; comp_i = 1'b1; comp_id_i = 6'd4;
        step();
        comp_i = 1'b0;
        step();
        chk("rc_pend", 32'(ip_o[3]), 32'h1);
        run_rounds(3, rounds);
        chk("rc_rounds", 32'(rounds), 32'd2);

        // Reset mid-ACTIVE with 4 queued edges on source 9 (bit 8)
        tm_i[8] = 1'b1;
        step();
        pulse(8); step(); step();
        claim(6'd9);
        for (int i = 0; i < 4; i++) pulse(8);
        step(); step();
        chk("rst_mid_setup", 32'(active_o[8]), 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_ip", ip_o, 32'h0);
        chk("rst_mid_act", active_o, 32'h0);
        step();
        rst_i = 1'b0;
        run_rounds(8, rounds);
        chk("rst_lost", 32'(rounds), 32'd0);
        pulse(8);
        step(); chk("rst_new_cnt", 32'(ip_o[8]), 32'h0);
        step(); chk("rst_new_pend", 32'(ip_o[8]), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
